// File: rtl/cl_bist_pkg.sv
// cl_bist_pkg: shared definitions for the cl logic unit and its BIST controller.
// Revision: 1.0
`default_nettype none

package cl_bist_pkg;

  localparam logic [1:0] CL_AND = 2'b00;
  localparam logic [1:0] CL_OR  = 2'b01;
  localparam logic [1:0] CL_XOR = 2'b10;
  localparam logic [1:0] CL_NOT = 2'b11;

  localparam int NUM_VECTORS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cl_ref.sv
// cl_ref: combinational golden model of the cl logic unit (same port order as cl).
// Revision: 1.0
`default_nettype none

module cl_ref
  import cl_bist_pkg::*;
(
  output logic       o_exp,
  input  logic       i_a,
  input  logic       i_b,
  input  logic [1:0] i_s
);

  always_comb begin
    o_exp = 1'b0;
    case (i_s)
      CL_AND:  o_exp = i_a & i_b;
      CL_OR:   o_exp = i_a | i_b;
      CL_XOR:  o_exp = i_a ^ i_b;
      CL_NOT:  o_exp = ~i_a;
      default: o_exp = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cl_bist.sv
// cl_bist: sweeps all 16 {S,a,b} vectors through cl, checks each result against
// cl_ref and reports pass/fail, mismatch count and the first failing vector.
// Revision: 1.0
`default_nettype none

module cl_bist
  import cl_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             cl_a,
  output logic             cl_b,
  output logic [1:0]       cl_S,
  input  logic             cl_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       first_fail_vec
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [3:0]    C_LAST_VEC    = 4'(NUM_VECTORS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_idx;
  logic [SW-1:0]   r_settle;
  logic            w_exp;
  logic            w_mismatch;

  // Golden model sees exactly what cl sees: the registered drive outputs.
  cl_ref u_ref (
    .o_exp (w_exp),
    .i_a   (cl_a),
    .i_b   (cl_b),
    .i_s   (cl_S)
  );

  // Case inequality so an X/Z from cl is always a mismatch.
  assign w_mismatch = (cl_out !== w_exp);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_APPLY;
      ST_APPLY:  w_next = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE: if (r_settle == C_SETTLE_LAST) w_next = ST_CHECK;
      ST_CHECK:  w_next = (r_idx == C_LAST_VEC) ? ST_DONE : ST_APPLY;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= 4'd0;
      r_settle       <= '0;
      cl_a           <= 1'b0;
      cl_b           <= 1'b0;
      cl_S           <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= '0;
      first_fail_vec <= 4'd0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            fail_cnt       <= '0;
            first_fail_vec <= 4'd0;
            pass           <= 1'b0;
            r_idx          <= 4'd0;
            busy           <= 1'b1;
          end
        end
        ST_APPLY: begin
          {cl_S, cl_a, cl_b} <= r_idx;
          r_settle           <= '0;
        end
        ST_SETTLE: r_settle <= r_settle + 1'b1;
        ST_CHECK: begin
          if (w_mismatch) begin
            fail_cnt <= fail_cnt + CNT_W'(1);
            if (fail_cnt == '0) first_fail_vec <= r_idx;
          end
          // Result registers become visible during the DONE cycle.
          if (r_idx == C_LAST_VEC) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (fail_cnt == '0) && !w_mismatch;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cl_bist.sv
// tb_cl_bist: drives cl_bist against a behavioural cl whose truth table can be
// corrupted at will; expectations come from the logic-unit rules in the bench.
`default_nettype none

module tb_cl_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        a0, b0, a1, b1;
  logic [1:0]  s0, s1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [4:0]  fc0, fc1;
  logic [3:0]  ffv0, ffv1;
  logic [15:0] tab0, tab1;
  logic        out0, out1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The "cl" units under test: a truth table indexed by {S,a,b}.
  assign out0 = tab0[{s0, a0, b0}];
  assign out1 = tab1[{s1, a1, b1}];

  cl_bist #(.SETTLE_CYCLES(2), .CNT_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .cl_a(a0), .cl_b(b0), .cl_S(s0), .cl_out(out0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_cnt(fc0), .first_fail_vec(ffv0)
  );

  cl_bist #(.SETTLE_CYCLES(0), .CNT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .cl_a(a1), .cl_b(b1), .cl_S(s1), .cl_out(out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_cnt(fc1), .first_fail_vec(ffv1)
  );

  function automatic logic gold(input int v);
    int s = v / 4;
    int a = (v / 2) % 2;
    int b = v % 2;
    case (s)
      0:       return logic'(a * b);
      1:       return logic'((a + b) > 0);
      2:       return logic'(a != b);
      default: return logic'(1 - a);
    endcase
  endfunction

  function automatic logic [15:0] good_table();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = gold(v);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run on dut0 with truth table t; expectations from the rules.
  task automatic run0(input string tag, input logic [15:0] t);
    int n, busy_n, exp_fc, exp_first;
    tab0 = t;
    exp_fc = 0;
    exp_first = 0;
    for (int v = 0; v < 16; v++) begin
      if (t[v] != gold(v)) begin
        if (exp_fc == 0) exp_first = v;
        exp_fc++;
      end
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    busy_n = 0;
    while (!done0 && n < 300) begin
      if (busy0) busy_n++;
      tick();
      n++;
    end
    chk({tag, " latency"}, n, 64);
    chk({tag, " busy_len"}, busy_n, 64);
    chk({tag, " busy_at_done"}, busy0, 0);
    chk({tag, " fail_cnt"}, fc0, exp_fc);
    chk({tag, " first_fail"}, ffv0, exp_first);
    chk({tag, " pass"}, pass0, (exp_fc == 0));
    chk({tag, " last_vec"}, {s0, a0, b0}, 4'hF);
    tick();
    chk({tag, " done_pulse"}, done0, 0);
    chk({tag, " pass_hold"}, pass0, (exp_fc == 0));
  endtask

  initial begin
    logic [15:0] t;
    logic        bad;
    int          n, runs;

    tab0 = good_table();
    tab1 = good_table();
    repeat (3) tick();
    chk("reset dut0", {busy0, done0, pass0, fc0, ffv0, s0, a0, b0}, 0);
    chk("reset dut1", {busy1, done1, pass1, fc1, ffv1, s1, a1, b1}, 0);
    rst_n = 1'b1;
    tick();

    run0("good", good_table());
    t = good_table();
    for (int v = 8; v < 12; v++) t[v] = ~t[v];
    run0("xnor", t);
    run0("invert", ~good_table());
    for (int r = 0; r < 3; r++) run0("random", 16'($urandom));

    // Reset in the middle of a run aborts it without a done pulse.
    tab0 = good_table();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset outs", {busy0, done0, pass0, fc0, ffv0, s0, a0, b0}, 0);
    bad = 1'b0;
    repeat (70) begin
      tick();
      if (done0 || busy0) bad = 1'b1;
    end
    chk("midreset quiet", bad, 0);
    rst_n = 1'b1;
    tick();
    run0("after_reset", good_table());

    // Zero settle window: 2 cycles per vector, done 32 cycles after start.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    bad = 1'b0;
    while (!done1 && n < 100) begin
      if (n % 2 == 1 && {s1, a1, b1} != 4'((n - 1) / 2)) bad = 1'b1;
      tick();
      n++;
    end
    chk("settle0 latency", n, 32);
    chk("settle0 step", bad, 0);
    chk("settle0 pass", pass1, 1);
    chk("settle0 fail_cnt", fc1, 0);

    // Start held high: back-to-back runs every 66 cycles, each passing.
    tab0 = good_table();
    start0 = 1'b1;
    tick();
    n = 0;
    runs = 0;
    bad = 1'b0;
    while (n < 200) begin
      if (done0) begin
        if (n != 64 + runs * 66 || !pass0) bad = 1'b1;
        runs++;
      end
      tick();
      n++;
    end
    start0 = 1'b0;
    chk("held runs", runs, 3);
    chk("held timing", bad, 0);
    n = 0;
    while (!done0 && n < 100) begin
      tick();
      n++;
    end
    chk("held final done", done0, 1);
    chk("held final pass", pass0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
